// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_conditioner : 2-flop sync, stability debounce, press strobe;          |
// | auto-repeat while held when BTN_AUTOREPEAT_EN is defined.   Rev 1.0       |
// +--------------------------------------------------------------------------+
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic pulse_out,
  output logic held
);

  if ((DEBOUNCE_CYCLES < 1) || (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) ||
      (REPEAT_DELAY < 1)    || (64'(REPEAT_DELAY)    >= (64'd1 << CNT_W)) ||
      (REPEAT_PERIOD < 1)   || (64'(REPEAT_PERIOD)   >= (64'd1 << CNT_W))) begin : g_bad_params
    $error("btn_conditioner: count parameters must be in [1, 2^CNT_W)");
  end

  localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_level;
  logic             r_pulse;
  logic             w_mismatch;
  logic             w_db_done;
  logic             w_level_nxt;
  logic             w_rise;
  logic             w_pulse_nxt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_mismatch  = r_sync2 ^ r_level;
  assign w_db_done   = w_mismatch && (r_db_cnt == c_db_last);
  assign w_level_nxt = r_level ^ w_db_done;
  assign w_rise      = w_db_done & ~r_level;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (!w_mismatch || w_db_done) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // The FSM acts on the next debounced level so release and press decisions
  // line up with the edge on which level_out itself changes.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             r_held;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pulse <= w_pulse_nxt;
      r_held  <= (w_state_nxt == S_REPEAT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_rise) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!w_level_nxt) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_delay_last) begin
          w_pulse_nxt = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!w_level_nxt) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_period_last) begin
          w_pulse_nxt = 1'b1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign held = r_held;
`else
  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESSED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (!w_level_nxt) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign held = 1'b0;
`endif

  assign level_out = r_level;
  assign pulse_out = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btn_conditioner : scoreboard bench for btn_conditioner.   Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  logic btn_in     = 1'b0;
  logic level_out;
  logic pulse_out;
  logic held;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];
  bit prev_pulse = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (8)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_in    (btn_in),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .held      (held)
  );

  // Every observed strobe is matched against the next scheduled edge.
  always @(posedge clk_100MHz) begin
    int e;
    cyc = cyc + 1;
    #1;
    if (pulse_out === 1'b1) begin
      total++;
      if (prev_pulse) begin
        bad++;
        $display("FAIL pulse_back_to_back cyc=%0d got=1 want=0", cyc);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected cyc=%0d got=1 want=0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL pulse_edge got=%0d want=%0d", cyc, e);
        end
      end
    end
    prev_pulse = (pulse_out === 1'b1);
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #2;
  endtask

  function automatic void push_sched(input int rise, input int fall);
    exp_q.push_back(rise);
    if (AR) begin
      for (int t = rise + RD; t < fall; t += RP) exp_q.push_back(t);
    end
  endfunction

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_pulses got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b0;
    repeat (3) tick();
    total += 3;
    if (level_out !== 1'b0) begin bad++; $display("FAIL reset_level got=%b want=0", level_out); end
    if (pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", pulse_out); end
    if (held !== 1'b0)      begin bad++; $display("FAIL reset_held got=%b want=0", held); end
    reset = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_glitch();
    tick();
    btn_in = 1'b1;
    for (int rel = 1; rel <= 16; rel++) begin
      tick();
      total++;
      if (level_out !== 1'b0) begin
        bad++;
        $display("FAIL glitch_level rel=%0d got=%b want=0", rel, level_out);
      end
      if (rel == 3) btn_in = 1'b0;
    end
    check_drained("glitch");
  endtask

  task automatic test_single_press();
    int t0;
    tick();
    t0 = cyc;
    btn_in = 1'b1;
    push_sched(t0 + 2 + D, t0 + 8 + 2 + D);
    for (int rel = 1; rel <= 20; rel++) begin
      tick();
      total += 2;
      if (level_out !== (rel >= 6 && rel < 14)) begin
        bad++;
        $display("FAIL single_level rel=%0d got=%b want=%b", rel, level_out, (rel >= 6 && rel < 14));
      end
      if (held !== 1'b0) begin
        bad++;
        $display("FAIL single_held rel=%0d got=%b want=0", rel, held);
      end
      if (rel == 8) btn_in = 1'b0;
    end
    check_drained("single");
  endtask

  task automatic test_autorepeat();
    int t0;
    logic el;
    logic eh;
    tick();
    t0 = cyc;
    btn_in = 1'b1;
    push_sched(t0 + 6, t0 + 46);
    for (int rel = 1; rel <= 52; rel++) begin
      tick();
      el = (rel >= 6 && rel < 46);
      eh = AR && (rel >= 16 && rel < 46);
      total += 2;
      if (level_out !== el) begin
        bad++;
        $display("FAIL repeat_level rel=%0d got=%b want=%b", rel, level_out, el);
      end
      if (held !== eh) begin
        bad++;
        $display("FAIL repeat_held rel=%0d got=%b want=%b", rel, held, eh);
      end
      if (rel == 40) btn_in = 1'b0;
    end
    check_drained("repeat");
  endtask

  task automatic test_reset_in_repeat();
    int t0;
    int t1;
    logic el;
    logic eh;
    tick();
    t0 = cyc;
    btn_in = 1'b1;
    push_sched(t0 + 6, t0 + 21);
    for (int rel = 1; rel <= 20; rel++) tick();
    reset = 1'b1;
    #1;
    total += 3;
    if (level_out !== 1'b0) begin bad++; $display("FAIL rstrep_level got=%b want=0", level_out); end
    if (pulse_out !== 1'b0) begin bad++; $display("FAIL rstrep_pulse got=%b want=0", pulse_out); end
    if (held !== 1'b0)      begin bad++; $display("FAIL rstrep_held got=%b want=0", held); end
    check_drained("rstrep_pre");
    repeat (2) tick();
    reset = 1'b0;
    t1 = cyc;
    push_sched(t1 + 6, t1 + 18);
    for (int rel = 1; rel <= 24; rel++) begin
      tick();
      el = (rel >= 6 && rel < 18);
      eh = AR && (rel >= 16 && rel < 18);
      total += 2;
      if (level_out !== el) begin
        bad++;
        $display("FAIL rstrep_level_after rel=%0d got=%b want=%b", rel, level_out, el);
      end
      if (held !== eh) begin
        bad++;
        $display("FAIL rstrep_held_after rel=%0d got=%b want=%b", rel, held, eh);
      end
      if (rel == 12) btn_in = 1'b0;
    end
    check_drained("rstrep");
  endtask

  task automatic test_bounce_in_repeat();
    int t0;
    logic el;
    logic eh;
    tick();
    t0 = cyc;
    btn_in = 1'b1;
    push_sched(t0 + 6, t0 + 46);
    for (int rel = 1; rel <= 52; rel++) begin
      tick();
      el = (rel >= 6 && rel < 46);
      eh = AR && (rel >= 16 && rel < 46);
      total += 2;
      if (level_out !== el) begin
        bad++;
        $display("FAIL bounce_level rel=%0d got=%b want=%b", rel, level_out, el);
      end
      if (held !== eh) begin
        bad++;
        $display("FAIL bounce_held rel=%0d got=%b want=%b", rel, held, eh);
      end
      // Two-cycle chatter from rel 20 to 39, final release after rel 40.
      if (rel >= 20 && rel < 40) btn_in = (((rel - 20) / 2) % 2) == 1;
      else if (rel >= 40) btn_in = 1'b0;
    end
    check_drained("bounce");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_autorepeat();
    test_reset_in_repeat();
    test_bounce_in_repeat();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
